// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, write-back bus type and helpers for the register file slice
// Purpose: constants and types shared by the write-back consumer and its scoreboard.
//   DATA_W   : register data width
//   ADDR_W   : register select width
//   NREGS    : number of architectural registers
//   REG_ZERO : select value of the hard-wired zero register
//   wb_bus   : stage-three write-back bundle {data, ws, we}
//   popcount : number of set bits in a busy vector
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] ws;
    logic              we;
  } wb_bus;

  function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard with stall detection
// Purpose: tracks which registers have an issued but not yet committed write,
//          stalls issue when a source operand is still in flight.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   wb_we, wb_ws       : retiring write-back (clears busy)
//   issue_valid/we/ws  : instruction issued by decode (sets busy)
//   rs1, rs2           : source selects of the issuing instruction
//   stall              : a source has an uncommitted pending write
//   pending_count      : registered count of busy registers
module hazard_scoreboard #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int NREGS  = pipe_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_ws,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_ws,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              stall,
  output logic [5:0]        pending_count
);
  import pipe_pkg::*;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             wb_clear;
  logic             issue_set;
  logic             hazard_a;
  logic             hazard_b;

  assign wb_clear = wb_we && (wb_ws != REG_ZERO);

  // A register retiring this cycle is satisfied by the bypass, so it is not a hazard.
  assign hazard_a = (rs1 != REG_ZERO) && busy[rs1] && !(wb_we && (wb_ws == rs1));
  assign hazard_b = (rs2 != REG_ZERO) && busy[rs2] && !(wb_we && (wb_ws == rs2));
  assign stall    = issue_valid && (hazard_a || hazard_b);

  assign issue_set = issue_valid && issue_we && (issue_ws != REG_ZERO) && !stall;

  // Clear first, then set: on the same register the younger issue wins.
  always_comb begin
    busy_next = busy;
    if (wb_clear) begin
      busy_next[wb_ws] = 1'b0;
    end
    if (issue_set) begin
      busy_next[issue_ws] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= popcount(busy_next);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - 32x32 register file with write-back commit, bypassed reads and scoreboard
// Purpose: commits stage-three results, serves two bypassed read ports to decode,
//          and reports operand hazards through the pending-write scoreboard.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   S3_ALUOUT, S3_WS, S3_WE     : write-back data, select, enable
//   ReadSelect1/2, ReadData1/2  : combinational, write-through bypassed read ports
//   IssueValid, IssueWE, IssueWS: decode issue, marks destination pending
//   Stall                       : a source operand is still in flight
//   PendingCount                : number of busy registers
module regfile_writeback #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int NREGS  = pipe_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] S3_ALUOUT,
  input  logic [ADDR_W-1:0] S3_WS,
  input  logic              S3_WE,
  input  logic [ADDR_W-1:0] ReadSelect1,
  input  logic [ADDR_W-1:0] ReadSelect2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              IssueValid,
  input  logic              IssueWE,
  input  logic [ADDR_W-1:0] IssueWS,
  output logic              Stall,
  output logic [5:0]        PendingCount
);
  import pipe_pkg::*;

  wb_bus            wb;
  logic [DATA_W-1:0] regs [NREGS];

  assign wb.data = S3_ALUOUT;
  assign wb.ws   = S3_WS;
  assign wb.we   = S3_WE;

  // r0 is never written, so its array slot stays at the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb.we && (wb.ws != REG_ZERO)) begin
      regs[wb.ws] <= wb.data;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadSelect1];
    if (ReadSelect1 == REG_ZERO) begin
      ReadData1 = '0;
    end else if (wb.we && (wb.ws == ReadSelect1)) begin
      ReadData1 = wb.data;
    end
  end

  always_comb begin
    ReadData2 = regs[ReadSelect2];
    if (ReadSelect2 == REG_ZERO) begin
      ReadData2 = '0;
    end else if (wb.we && (wb.ws == ReadSelect2)) begin
      ReadData2 = wb.data;
    end
  end

  hazard_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .wb_we         (wb.we),
    .wb_ws         (wb.ws),
    .issue_valid   (IssueValid),
    .issue_we      (IssueWE),
    .issue_ws      (IssueWS),
    .rs1           (ReadSelect1),
    .rs2           (ReadSelect2),
    .stall         (Stall),
    .pending_count (PendingCount)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] S3_ALUOUT;
  logic [4:0]  S3_WS;
  logic        S3_WE;
  logic [4:0]  ReadSelect1;
  logic [4:0]  ReadSelect2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        IssueValid;
  logic        IssueWE;
  logic [4:0]  IssueWS;
  logic        Stall;
  logic [5:0]  PendingCount;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .S3_ALUOUT    (S3_ALUOUT),
    .S3_WS        (S3_WS),
    .S3_WE        (S3_WE),
    .ReadSelect1  (ReadSelect1),
    .ReadSelect2  (ReadSelect2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .IssueValid   (IssueValid),
    .IssueWE      (IssueWE),
    .IssueWS      (IssueWS),
    .Stall        (Stall),
    .PendingCount (PendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] ws, input logic [31:0] d);
    S3_WE = we; S3_WS = ws; S3_ALUOUT = d;
  endtask

  task automatic issue(input logic v, input logic we, input logic [4:0] ws);
    IssueValid = v; IssueWE = we; IssueWS = ws;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    ReadSelect1 = a; ReadSelect2 = b;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b0, 1'b0, 5'd0);
    ReadSelect1 = '0; ReadSelect2 = '0;

    // 1. reset then read
    tick(); tick();
    reset = 1'b0;
    rd(5'd5, 5'd31);
    check("rst_rd1",   ReadData1, 32'd0);
    check("rst_rd2",   ReadData2, 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_pend",  32'(PendingCount), 32'd0);

    // 2. write with same-cycle bypass, then array read
    wb(1'b1, 5'd7, 32'hDEADBEEF);
    rd(5'd7, 5'd7);
    check("byp_rd1", ReadData1, 32'hDEADBEEF);
    check("byp_rd2", ReadData2, 32'hDEADBEEF);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    rd(5'd7, 5'd0);
    check("arr_rd1", ReadData1, 32'hDEADBEEF);
    check("arr_r0",  ReadData2, 32'd0);

    // 3. r0 protection
    wb(1'b1, 5'd0, 32'h12345678);
    rd(5'd0, 5'd0);
    check("r0_byp", ReadData1, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    rd(5'd0, 5'd7);
    check("r0_after", ReadData1, 32'd0);
    check("r7_keep",  ReadData2, 32'hDEADBEEF);

    // 4. scoreboard hazard on r3
    issue(1'b1, 1'b1, 5'd3);
    rd(5'd0, 5'd0);
    check("iss3_nostall", 32'(Stall), 32'd0);
    tick();
    check("iss3_pend", 32'(PendingCount), 32'd1);
    issue(1'b1, 1'b1, 5'd10);  // stalled, must not mark r10
    rd(5'd3, 5'd0);
    check("haz_stall", 32'(Stall), 32'd1);
    tick();
    check("haz_stall2", 32'(Stall), 32'd1);
    check("haz_pend",   32'(PendingCount), 32'd1);
    issue(1'b1, 1'b0, 5'd0);
    wb(1'b1, 5'd3, 32'hA5A50003);
    rd(5'd3, 5'd0);
    check("wb3_stall", 32'(Stall), 32'd0);
    check("wb3_byp",   ReadData1, 32'hA5A50003);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b0, 1'b0, 5'd0);
    rd(5'd3, 5'd0);
    check("wb3_pend", 32'(PendingCount), 32'd0);
    check("wb3_arr",  ReadData1, 32'hA5A50003);

    // source B hazard
    issue(1'b1, 1'b1, 5'd6);
    rd(5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b0, 5'd0);
    rd(5'd1, 5'd6);
    check("hazb_stall", 32'(Stall), 32'd1);
    issue(1'b0, 1'b0, 5'd0);
    #1;
    check("hazb_novalid", 32'(Stall), 32'd0);
    wb(1'b1, 5'd6, 32'h66);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    check("hazb_pend", 32'(PendingCount), 32'd0);

    // 5. simultaneous set/clear on r4
    issue(1'b1, 1'b1, 5'd4);
    rd(5'd0, 5'd0);
    tick();
    check("r4_pend1", 32'(PendingCount), 32'd1);
    wb(1'b1, 5'd4, 32'h44);
    issue(1'b1, 1'b1, 5'd4);
    #1;
    check("r4_nostall", 32'(Stall), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b1, 1'b0, 5'd0);
    rd(5'd4, 5'd0);
    check("r4_pend_same", 32'(PendingCount), 32'd1);
    check("r4_still_busy", 32'(Stall), 32'd1);
    issue(1'b0, 1'b0, 5'd0);
    wb(1'b1, 5'd4, 32'h45);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    check("r4_cleared", 32'(PendingCount), 32'd0);

    // 6. reset mid-operation
    wb(1'b1, 5'd1, 32'h11);
    issue(1'b1, 1'b1, 5'd9);
    rd(5'd0, 5'd0);
    tick();
    issue(1'b0, 1'b0, 5'd0);
    wb(1'b1, 5'd2, 32'h22);
    tick();
    wb(1'b1, 5'd3, 32'h33);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    rd(5'd2, 5'd9);
    check("pre_rst_r2",   ReadData2 == 32'h0 ? ReadData1 : ReadData1, 32'h22);
    check("pre_rst_pend", 32'(PendingCount), 32'd1);
    reset = 1'b1;
    wb(1'b1, 5'd2, 32'hFFFF0002);
    issue(1'b1, 1'b1, 5'd12);
    tick();
    reset = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    issue(1'b0, 1'b0, 5'd0);
    rd(5'd1, 5'd2);
    check("mrst_r1", ReadData1, 32'd0);
    check("mrst_r2", ReadData2, 32'd0);
    rd(5'd3, 5'd7);
    check("mrst_r3", ReadData1, 32'd0);
    check("mrst_r7", ReadData2, 32'd0);
    check("mrst_pend", 32'(PendingCount), 32'd0);
    issue(1'b1, 1'b0, 5'd0);
    rd(5'd9, 5'd12);
    check("mrst_stall", 32'(Stall), 32'd0);
    issue(1'b0, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
